cpu_mc: RTL and testbench

Parametrised multi-cycle successor to the lab CPU. It adds a program counter, instruction fetch, LDR/STR and HALT over a request/acknowledge memory port, and generalises the datapath width. The register file, shifter, ALU and status flags are retained, and the core now runs from reset without an external start strobe. It sits between the top level and a single-ported program/data memory.

---
 rtl/cpu_mc.sv | 245 ++++++++++++++++++++++++
 tb/tb_cpu_mc.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle core with PC, fetch, LDR/STR and HALT over a
// request/acknowledge memory port; register file, shifter, ALU and flags.
module cpu_mc #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 9,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_REG,
        S_WR_IMM,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
    localparam int MSB = DATA_W - 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic [DATA_W-1:0] r_q [8];
    logic [DATA_W-1:0] r_d [8];
    logic              n_q, n_d;
    logic              v_q, v_d;
    logic              z_q, z_d;
    logic              req_q, req_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic [DATA_W-1:0] sximm8;
    logic [DATA_W-1:0] sximm5;

    logic is_movi;
    logic is_movr;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;
    logic is_ldr;
    logic is_str;
    logic is_halt;
    logic ack_ok;

    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_sh;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_res;
    logic              ovf;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];
    assign sximm8 = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};

    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);
    assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
    assign is_str  = (opcode == 3'b100) && (op == 2'b00);
    assign is_halt = (opcode == 3'b111);

    // an ack only counts while a request is actually outstanding
    assign ack_ok = req_q && mem_ack;

    always_comb begin
        a_in = (is_movr || is_mvn) ? '0 : a_q;
        unique case (sh)
            2'b00: b_sh = b_q;
            2'b01: b_sh = {b_q[MSB-1:0], 1'b0};
            2'b10: b_sh = {1'b0, b_q[MSB:1]};
            2'b11: b_sh = {b_q[MSB], b_q[MSB:1]};
        endcase
        sum  = a_in + b_sh;
        diff = a_in - b_sh;
        ovf  = (a_in[MSB] ^ b_sh[MSB]) & (diff[MSB] ^ a_in[MSB]);
        alu_res = b_sh;
        if (is_alu) begin
            unique case (op)
                2'b00: alu_res = sum;
                2'b01: alu_res = diff;
                2'b10: alu_res = a_in & b_sh;
                2'b11: alu_res = ~b_sh;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        r_d     = r_q;
        n_d     = n_q;
        v_d     = v_q;
        z_d     = z_q;
        unique case (state_q)
            S_FETCH: begin
                if (ack_ok) begin
                    ir_d    = read_data[15:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_movi:               state_d = S_WR_IMM;
                    is_movr || is_mvn:     state_d = S_GET_B;
                    is_alu && !is_mvn:     state_d = S_GET_A;
                    is_ldr || is_str:      state_d = S_GET_A;
                    is_halt:               state_d = S_HALT;
                    default:               state_d = S_FETCH;
                endcase
            end
            S_GET_A: begin
                a_d     = r_q[rn];
                state_d = (is_ldr || is_str) ? S_ADDR : S_GET_B;
            end
            S_GET_B: begin
                b_d     = is_str ? r_q[rd] : r_q[rm];
                state_d = is_str ? S_MEM_WR : S_EXEC;
            end
            S_EXEC: begin
                if (is_cmp) begin
                    n_d     = diff[MSB];
                    z_d     = (diff == '0);
                    v_d     = ovf;
                    state_d = S_FETCH;
                end else begin
                    c_d     = alu_res;
                    state_d = S_WR_REG;
                end
            end
            S_WR_REG: begin
                r_d[rd] = c_q;
                state_d = S_FETCH;
            end
            S_WR_IMM: begin
                r_d[rn] = sximm8;
                state_d = S_FETCH;
            end
            S_ADDR: begin
                c_d     = a_q + sximm5;
                state_d = is_ldr ? S_MEM_RD : S_GET_B;
            end
            S_MEM_RD: begin
                if (ack_ok) begin
                    r_d[rd] = read_data;
                    state_d = S_FETCH;
                end
            end
            S_MEM_WR: begin
                if (ack_ok) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // request is registered from the state being entered
        req_d = (state_d == S_FETCH) || (state_d == S_MEM_RD)
             || (state_d == S_MEM_WR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RST;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            req_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            n_q     <= n_d;
            v_q     <= v_d;
            z_q     <= z_d;
            req_q   <= req_d;
            r_q     <= r_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_we     = req_q && (state_q == S_MEM_WR);
    assign mem_addr   = !req_q ? '0
                      : (state_q == S_FETCH) ? pc_q
                      : c_q[ADDR_W-1:0];
    assign write_data = mem_we ? b_q : '0;
    assign out        = c_q;
    assign N          = n_q;
    assign V          = v_q;
    assign Z          = z_q;
    assign pc         = pc_q;
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: program-driven bench for cpu_mc with a behavioural memory
// and a store scoreboard; covers two parameter sets.
module tb_cpu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic        req0, we0, ack0;
    logic [8:0]  addr0, pc0;
    logic [15:0] wd0, rd0, out0;
    logic        n0, v0, z0, halt0;

    logic        req1, we1, ack1;
    logic [3:0]  addr1, pc1;
    logic [23:0] wd1, rd1, out1;
    logic        n1, v1, z1, halt1;

    logic [15:0] mem0 [512];
    logic [23:0] mem1 [16];
    logic        tie0;
    int          dly0;
    int          cnt0;
    logic        hold_en;
    logic        busy0;
    logic [8:0]  st_addr;
    logic        st_we;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          unit;
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;
    sb_t sbq[$];

    cpu_mc #(.DATA_W(16), .ADDR_W(9), .RESET_PC(0)) dut0 (
        .clk(clk), .reset(rst0), .mem_req(req0), .mem_we(we0),
        .mem_addr(addr0), .write_data(wd0), .read_data(rd0),
        .mem_ack(ack0), .out(out0), .N(n0), .V(v0), .Z(z0),
        .pc(pc0), .halted(halt0)
    );

    cpu_mc #(.DATA_W(24), .ADDR_W(4), .RESET_PC(0)) dut1 (
        .clk(clk), .reset(rst1), .mem_req(req1), .mem_we(we1),
        .mem_addr(addr1), .write_data(wd1), .read_data(rd1),
        .mem_ack(ack1), .out(out1), .N(n1), .V(v1), .Z(z1),
        .pc(pc1), .halted(halt1)
    );

    assign rd0  = mem0[addr0];
    assign rd1  = mem1[addr1];
    assign ack0 = tie0 | (req0 && (cnt0 == dly0));
    assign ack1 = req1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input int u, input logic [31:0] a,
                           input logic [31:0] d);
        sb_t e;
        e.unit = u;
        e.addr = a;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input int u, input logic [31:0] a,
                          input logic [31:0] d);
        sb_t e;
        if (sbq.size() == 0) begin
            chk("sb_unexpected_store", a, 32'hFFFF_FFFF);
        end else begin
            e = sbq.pop_front();
            chk("sb_unit", u, e.unit);
            chk("sb_addr", a, e.addr);
            chk("sb_data", d, e.data);
        end
    endtask

    always @(posedge clk or negedge rst0) begin
        if (!rst0) cnt0 <= 0;
        else if (req0 && ack0) cnt0 <= 0;
        else if (req0) cnt0 <= cnt0 + 1;
    end

    always @(negedge clk) begin
        if (rst0 && req0) begin
            if (!busy0) begin
                busy0   = 1'b1;
                st_addr = addr0;
                st_we   = we0;
            end
            if (ack0) begin
                if (hold_en) begin
                    chk("hold_addr", addr0, st_addr);
                    chk("hold_we", we0, st_we);
                end
                busy0 = 1'b0;
                if (we0) begin
                    mem0[addr0] = wd0;
                    sb_pop(0, 32'(addr0), 32'(wd0));
                end
            end
        end else begin
            busy0 = 1'b0;
        end
        if (rst1 && req1 && ack1 && we1) begin
            mem1[addr1] = wd1;
            sb_pop(1, 32'(addr1), 32'(wd1));
        end
    end

    function automatic logic [15:0] enc(input logic [2:0] opc,
        input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rd,
        input logic [1:0] sh, input logic [2:0] rm);
        return {opc, op, rn, rd, sh, rm};
    endfunction

    function automatic logic [15:0] movi(input logic [2:0] rn,
                                         input logic [7:0] imm);
        return {3'b110, 2'b10, rn, imm};
    endfunction

    function automatic logic [15:0] ldr(input logic [2:0] rd,
        input logic [2:0] rn, input logic [4:0] imm);
        return {3'b011, 2'b00, rn, rd, imm};
    endfunction

    function automatic logic [15:0] str(input logic [2:0] rd,
        input logic [2:0] rn, input logic [4:0] imm);
        return {3'b100, 2'b00, rn, rd, imm};
    endfunction

    localparam logic [15:0] HLT = 16'hE000;

    task automatic reset0();
        @(negedge clk);
        rst0 = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 512; i++) mem0[i] = 16'h0000;
    endtask

    task automatic run(input int u, input int maxc, output int cyc,
                       output int freq, output logic [31:0] faddr);
        logic h;
        cyc   = 0;
        freq  = -1;
        faddr = '1;
        h     = 1'b0;
        @(negedge clk);
        if (u == 0) rst0 = 1'b1;
        else rst1 = 1'b1;
        while (cyc < maxc && !h) begin
            @(posedge clk);
            #1;
            cyc++;
            if (freq < 0 && (u == 0 ? req0 : req1)) begin
                freq  = cyc;
                faddr = (u == 0) ? 32'(addr0) : 32'(addr1);
            end
            h = (u == 0) ? halt0 : halt1;
        end
        if (!h) chk("timeout_halt", h, 1'b1);
    endtask

    initial begin
        int cyc, fr;
        logic [31:0] fa;
        rst0 = 1'b0;
        rst1 = 1'b0;
        tie0 = 1'b0;
        dly0 = 0;
        hold_en = 1'b0;
        busy0 = 1'b0;
        for (int i = 0; i < 512; i++) mem0[i] = 16'h0000;
        for (int i = 0; i < 16; i++) mem1[i] = 24'h0;
        repeat (3) @(negedge clk);

        chk("rst_mem0", {req0, we0, addr0, wd0}, '0);
        chk("rst_arch0", {out0, n0, v0, z0, pc0, halt0}, '0);
        chk("rst_all1", {req1, we1, addr1, wd1, out1, n1, v1, z1, pc1, halt1},
            '0);

        // A: MOV imm x2 then HALT, ack tied high
        tie0 = 1'b1;
        mem0[0] = movi(3'd0, 8'd5);
        mem0[1] = movi(3'd1, 8'hFE);
        mem0[2] = HLT;
        run(0, 100, cyc, fr, fa);
        chk("A_cycles", cyc, 9);
        chk("A_first_req", fr, 1);
        chk("A_first_addr", fa, 0);
        chk("A_pc", pc0, 3);
        chk("A_out", out0, 0);

        // B: stores of R0/R1, ADD with LSL, CMP equal
        reset0();
        tie0 = 1'b0;
        mem0[0] = movi(3'd0, 8'd5);
        mem0[1] = movi(3'd1, 8'hFE);
        mem0[2] = movi(3'd7, 8'd64);
        mem0[3] = str(3'd0, 3'd7, 5'd0);
        mem0[4] = str(3'd1, 3'd7, 5'd1);
        mem0[5] = enc(3'b101, 2'b00, 3'd0, 3'd2, 2'b01, 3'd1);
        mem0[6] = enc(3'b101, 2'b01, 3'd0, 3'd0, 2'b00, 3'd0);
        mem0[7] = HLT;
        sb_push(0, 64, 32'h0005);
        sb_push(0, 65, 32'hFFFE);
        run(0, 200, cyc, fr, fa);
        chk("B_cycles", cyc, 35);
        chk("B_out", out0, 16'h0001);
        chk("B_nvz", {n0, v0, z0}, 3'b001);
        chk("B_pc", pc0, 8);
        chk("B_sb_left", sbq.size(), 0);

        // C: three-cycle ack delay, LDR/STR with negative offset, CMP ovf
        reset0();
        dly0 = 3;
        hold_en = 1'b1;
        mem0[0]   = movi(3'd1, 8'hFF);
        mem0[1]   = enc(3'b110, 2'b00, 3'd0, 3'd0, 2'b10, 3'd1);
        mem0[2]   = movi(3'd3, 8'd4);
        mem0[3]   = movi(3'd7, 8'd100);
        mem0[4]   = ldr(3'd5, 3'd7, 5'd0);
        mem0[5]   = str(3'd5, 3'd3, 5'h1F);
        mem0[6]   = ldr(3'd4, 3'd3, 5'h1F);
        mem0[7]   = str(3'd4, 3'd7, 5'd1);
        mem0[8]   = enc(3'b101, 2'b11, 3'd0, 3'd6, 2'b00, 3'd0);
        mem0[9]   = enc(3'b101, 2'b01, 3'd0, 3'd0, 2'b00, 3'd1);
        mem0[10]  = HLT;
        mem0[100] = 16'h00AB;
        sb_push(0, 3, 32'h00AB);
        sb_push(0, 101, 32'h00AB);
        run(0, 400, cyc, fr, fa);
        chk("C_cycles", cyc, 94);
        chk("C_out", out0, 16'h8000);
        chk("C_nvz", {n0, v0, z0}, 3'b110);
        chk("C_pc", pc0, 11);
        chk("C_sb_left", sbq.size(), 0);
        hold_en = 1'b0;

        // D: reset asserted while a store waits for its ack
        reset0();
        dly0 = 10;
        mem0[0] = movi(3'd3, 8'd4);
        mem0[1] = movi(3'd0, 8'd9);
        mem0[2] = str(3'd0, 3'd3, 5'd4);
        mem0[3] = HLT;
        @(negedge clk);
        rst0 = 1'b1;
        for (int i = 0; i < 200 && !we0; i++) @(negedge clk);
        chk("D_store_seen", we0, 1'b1);
        @(posedge clk);
        #3;
        rst0 = 1'b0;
        #1;
        chk("D_abort_req", req0, 1'b0);
        chk("D_abort_we", we0, 1'b0);
        repeat (2) @(negedge clk);
        chk("D_no_write", mem0[8], 16'h0000);
        dly0 = 0;
        sb_push(0, 8, 32'h0009);
        run(0, 200, cyc, fr, fa);
        chk("D_cycles", cyc, 15);
        chk("D_first_req", fr, 1);
        chk("D_restart_addr", fa, 0);
        chk("D_pc", pc0, 4);
        chk("D_sb_left", sbq.size(), 0);

        // E: 24-bit core, 16-word memory, NOP run and PC wrap
        mem1[0] = {8'h00, movi(3'd0, 8'h80)};
        mem1[2] = {8'h00, str(3'd0, 3'd1, 5'd0)};
        sb_push(1, 0, 32'hFF_FF80);
        run(1, 200, cyc, fr, fa);
        chk("E_cycles", cyc, 40);
        chk("E_pc_wrap", pc1, 1);
        chk("E_out", out1, 24'h0);
        chk("E_sb_left", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
